// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipe sequencing slice.
//   state_t       - pipe_scheduler FSM states
//   COORD_W       - coordinate width (11-bit unsigned screen coordinates)
//   SCREEN_W/H    - visible screen size
//   PIPE_HALF_W   - half width of a pipe body around its x centre
//   PIPE_BEVEL    - width of the pipe cap bevel
//   lfsr_advance  - one step of the 16-bit Fibonacci LFSR used for gap heights
package pipe_pkg;
  localparam int COORD_W     = 11;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PIPE_HALF_W = 30;
  localparam int PIPE_BEVEL  = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERASE  = 3'd1,
    E_WAIT = 3'd2,
    MOVE   = 3'd3,
    DRAW   = 3'd4,
    D_WAIT = 3'd5
  } state_t;

  // Taps 0,2,3,5 fed back into the MSB while the register shifts right.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
endpackage

// File: rtl/pipe_lfsr.sv
// pipe_lfsr: 16-bit Fibonacci LFSR that advances only when asked.
//   clk, reset : clock, synchronous active-high reset (loads SEED)
//   step       : advance one position on this edge
//   value      : current register contents
module pipe_lfsr
  import pipe_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] value
);
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else if (step) begin
      value <= lfsr_advance(value);
    end
  end
endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: owns the on-screen pipe positions and sequences the drawer.
// Each frame every pipe gets an erase pass at its old position (pen=0),
// then a one-cycle move/respawn, then a draw pass at the new position (pen=1).
//   clk, reset     : clock, synchronous active-high reset
//   frame_tick     : one-cycle frame start pulse
//   run            : 1 = scroll this frame, 0 = redraw in place
//   draw_done      : drawer completion pulse
//   draw_enable    : request to drawer (registered)
//   pipe_x, pipe_y : x centre / gap y of the pipe being drawn
//   pen            : 0 erase, 1 draw
//   busy           : frame in progress
//   frame_overrun  : pulse when frame_tick arrives while busy
//   pass_pulse     : pulse when a pipe respawns
//
// Drawer handshake: draw_enable rises with pipe_x/pipe_y/pen already valid and
// all four hold until the cycle draw_done is sampled high; draw_enable falls on
// that same edge and stays low for at least one cycle before the next pass.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int          NUM_PIPES   = 3,
  parameter int          START_X     = 200,
  parameter int          SPACING     = 200,
  parameter int          SPAWN_X     = 600,
  parameter int          MIN_X       = 31,
  parameter int          SPEED       = 1,
  parameter int          Y_MIN       = 250,
  parameter int          INIT_Y_STEP = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                run,
  input  logic                draw_done,
  output logic                draw_enable,
  output logic [COORD_W-1:0]  pipe_x,
  output logic [COORD_W-1:0]  pipe_y,
  output logic                pen,
  output logic                busy,
  output logic                frame_overrun,
  output logic                pass_pulse
);
  // Arrays are sized for the largest supported count so a 2-bit index never
  // reaches past the end; entries beyond NUM_PIPES are never selected.
  localparam int MAX_PIPES = 4;

  state_t             state, state_next;
  logic [1:0]         idx, idx_next;
  logic [COORD_W-1:0] pos_x [MAX_PIPES];
  logic [COORD_W-1:0] pos_y [MAX_PIPES];
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [COORD_W-1:0] pipe_x_next, pipe_y_next;
  logic               draw_enable_next, pen_next, busy_next;
  logic               frame_overrun_next, pass_pulse_next;
  logic               respawn, moving;
  logic [15:0]        lfsr_value, lfsr_next;

  assign cur_x     = pos_x[idx];
  assign cur_y     = pos_y[idx];
  assign respawn   = (state == MOVE) && run && (cur_x < COORD_W'(MIN_X + SPEED));
  assign moving    = (state == MOVE) && run && !respawn;
  assign lfsr_next = lfsr_advance(lfsr_value);

  pipe_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (respawn),
    .value (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= 2'd0;
      draw_enable   <= 1'b0;
      pipe_x        <= '0;
      pipe_y        <= '0;
      pen           <= 1'b0;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
      pass_pulse    <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      draw_enable   <= draw_enable_next;
      pipe_x        <= pipe_x_next;
      pipe_y        <= pipe_y_next;
      pen           <= pen_next;
      busy          <= busy_next;
      frame_overrun <= frame_overrun_next;
      pass_pulse    <= pass_pulse_next;
    end
  end

  always_comb begin
    state_next         = state;
    idx_next           = idx;
    draw_enable_next   = draw_enable;
    pipe_x_next        = pipe_x;
    pipe_y_next        = pipe_y;
    pen_next           = pen;
    busy_next          = busy;
    frame_overrun_next = frame_tick && (state != IDLE);
    pass_pulse_next    = respawn;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_next = ERASE;
          idx_next   = 2'd0;
          busy_next  = 1'b1;
        end
      end
      ERASE: begin
        pipe_x_next      = cur_x;
        pipe_y_next      = cur_y;
        pen_next         = 1'b0;
        draw_enable_next = 1'b1;
        state_next       = E_WAIT;
      end
      E_WAIT: begin
        if (draw_done) begin
          draw_enable_next = 1'b0;
          state_next       = MOVE;
        end
      end
      MOVE: begin
        state_next = DRAW;
      end
      DRAW: begin
        pipe_x_next      = cur_x;
        pipe_y_next      = cur_y;
        pen_next         = 1'b1;
        draw_enable_next = 1'b1;
        state_next       = D_WAIT;
      end
      D_WAIT: begin
        if (draw_done) begin
          draw_enable_next = 1'b0;
          if (idx == 2'(NUM_PIPES - 1)) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end else begin
            idx_next   = idx + 2'd1;
            state_next = ERASE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Positions change only in MOVE; the comparison against MIN_X+SPEED keeps
  // the subtraction from ever wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_PIPES; i++) begin
        pos_x[i] <= COORD_W'(START_X + i * SPACING);
        pos_y[i] <= COORD_W'(Y_MIN + i * INIT_Y_STEP);
      end
    end else if (respawn) begin
      pos_x[idx] <= COORD_W'(SPAWN_X);
      pos_y[idx] <= COORD_W'(Y_MIN) + COORD_W'(lfsr_next[6:0]);
    end else if (moving) begin
      pos_x[idx] <= cur_x - COORD_W'(SPEED);
    end
  end
endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: self-checking bench for pipe_scheduler with a
// variable-latency drawer model and an expected-pass queue.
module tb_pipe_scheduler;
  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic        draw_done;
  logic        draw_enable;
  logic [10:0] pipe_x, pipe_y;
  logic        pen, busy, frame_overrun, pass_pulse;

  pipe_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .run           (run),
    .draw_done     (draw_done),
    .draw_enable   (draw_enable),
    .pipe_x        (pipe_x),
    .pipe_y        (pipe_y),
    .pen           (pen),
    .busy          (busy),
    .frame_overrun (frame_overrun),
    .pass_pulse    (pass_pulse)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [22:0] exp_q[$];
  logic [22:0] obs_q[$];
  int          pass_cnt = 0;
  int          pp_cnt = 0;
  int          ov_cnt = 0;
  int          lat_lo = 1;
  int          lat_hi = 3;

  // reference model of pipe positions
  logic [10:0] mx [NP];
  logic [10:0] my [NP];
  logic [15:0] mlfsr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] pk(input int x, input int y, input int p);
    return {x[10:0], y[10:0], p[0]};
  endfunction

  function automatic logic [15:0] lfsr_model(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i] = 11'(200 + 200 * i);
      my[i] = 11'(250 + 32 * i);
    end
    mlfsr = 16'hACE1;
  endtask

  task automatic model_frame(input logic r);
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back({mx[i], my[i], 1'b0});
      if (r) begin
        if (mx[i] < 11'd32) begin
          mlfsr = lfsr_model(mlfsr);
          mx[i] = 11'd600;
          my[i] = 11'd250 + {4'd0, mlfsr[6:0]};
        end else begin
          mx[i] = mx[i] - 11'd1;
        end
      end
      exp_q.push_back({mx[i], my[i], 1'b1});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_en"}, draw_enable, 0);
    check_eq({tag, "_pen"}, pen, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ovr"}, frame_overrun, 0);
    check_eq({tag, "_pp"}, pass_pulse, 0);
    check_eq({tag, "_x"}, pipe_x, 0);
    check_eq({tag, "_y"}, pipe_y, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
  endtask

  // driver tasks
  task automatic start_frame(input logic r);
    @(negedge clk);
    run = r;
    frame_tick = 1'b1;
    model_frame(r);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_passes(input string tag, input int target);
    int n;
    n = 0;
    while (pass_cnt < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_reach"}, pass_cnt >= target, 1);
  endtask

  task automatic check_s1_passes(input string tag);
    logic [22:0] s1_exp [6];
    s1_exp[0] = pk(200, 250, 0);
    s1_exp[1] = pk(199, 250, 1);
    s1_exp[2] = pk(400, 282, 0);
    s1_exp[3] = pk(399, 282, 1);
    s1_exp[4] = pk(600, 314, 0);
    s1_exp[5] = pk(599, 314, 1);
    check_eq({tag, "_npass"}, obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      for (int i = 0; i < 6; i++) check_eq($sformatf("%s_pass%0d", tag, i), obs_q[i], s1_exp[i]);
    end
  endtask

  // drawer model: accepts a pass on enable, answers after lat cycles
  initial begin
    logic [22:0] cap;
    logic [22:0] e;
    int          lat;
    logic        stable;
    logic        aborted;
    draw_done = 1'b0;
    forever begin
      @(negedge clk);
      if (draw_enable && !reset) begin
        cap = {pipe_x, pipe_y, pen};
        obs_q.push_back(cap);
        pass_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("extra_pass", draw_enable, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("pass", cap, e);
        end
        lat = $urandom_range(lat_hi, lat_lo);
        stable = 1'b1;
        aborted = 1'b0;
        for (int k = 1; k < lat; k++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (!draw_enable || {pipe_x, pipe_y, pen} !== cap) stable = 1'b0;
        end
        if (!aborted) begin
          draw_done = 1'b1;
          @(negedge clk);
          draw_done = 1'b0;
          if (!reset) begin
            check_eq("stable", stable, 1);
            check_eq("enable_fall", draw_enable, 0);
          end
        end
      end
    end
  end

  // pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (pass_pulse) pp_cnt++;
      if (frame_overrun) ov_cnt++;
    end
  end

  initial begin
    int base;
    int pp0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("init");
    reset = 1'b0;

    // scenario 1: one scrolling frame, with start latency
    start_frame(1'b1);
    check_eq("s1_busy_rise", busy, 1);
    check_eq("s1_en_lat1", draw_enable, 0);
    @(negedge clk);
    check_eq("s1_en_lat2", draw_enable, 1);
    wait_idle("s1");
    check_s1_passes("s1");

    // scenario 2: paused frames redraw in place
    do_reset();
    start_frame(1'b0);
    wait_idle("s2a");
    start_frame(1'b0);
    wait_idle("s2b");
    check_eq("s2_n", obs_q.size(), 12);
    if (obs_q.size() == 12) begin
      check_eq("s2_e0", obs_q[0], pk(200, 250, 0));
      check_eq("s2_d0", obs_q[1], pk(200, 250, 1));
      check_eq("s2_e0_again", obs_q[6], pk(200, 250, 0));
      check_eq("s2_d2_again", obs_q[11], pk(600, 314, 1));
    end

    // scenario 3: pipe 0 walks down to MIN_X and respawns
    pp0 = pp_cnt;
    for (int f = 0; f < 169; f++) begin
      start_frame(1'b1);
      wait_idle("s3f");
    end
    check_eq("s3_no_early_respawn", pp_cnt - pp0, 0);
    obs_q.delete();
    start_frame(1'b1);
    wait_idle("s3");
    check_eq("s3_npass", obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      check_eq("s3_erase", obs_q[0], pk(31, 250, 0));
      check_eq("s3_draw", obs_q[1], pk(600, 362, 1));
    end
    check_eq("s3_pass_pulse", pp_cnt - pp0, 1);

    // scenario 4: long, variable drawer latency
    lat_lo = 1;
    lat_hi = 500;
    for (int f = 0; f < 2; f++) begin
      start_frame(1'b1);
      wait_idle("s4");
    end

    // scenario 5: frame_tick during pass 3 is reported and ignored
    lat_lo = 20;
    lat_hi = 40;
    base = pass_cnt;
    pp0 = ov_cnt;
    start_frame(1'b1);
    wait_passes("s5", base + 3);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle("s5");
    check_eq("s5_overrun", ov_cnt - pp0, 1);
    check_eq("s5_passes", pass_cnt - base, 6);
    lat_lo = 1;
    lat_hi = 4;
    start_frame(1'b1);
    wait_idle("s5_next");

    // scenario 6: reset while pipe 1 draw pass is outstanding
    lat_lo = 400;
    lat_hi = 500;
    base = pass_cnt;
    start_frame(1'b1);
    wait_passes("s6", base + 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("s6_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
    lat_lo = 1;
    lat_hi = 4;
    start_frame(1'b1);
    wait_idle("s6");
    check_s1_passes("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
